// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: LEGv8 multi-cycle sequencer (FETCH, EX0, EX1, HALT).
// Decodes the externally held instruction register into a packed 31-bit control
// word plus a K_BITS-wide constant each cycle. Only the state register is
// clocked; controlWord, K and illegal are combinational from state and
// instruction.
// Optional build macro MCU_ILLEGAL_TRAP_EN: illegal opcodes trap into HALT
// instead of being skipped as a NOP.
`timescale 1ns/1ps
module multicycle_control_unit #(
    parameter int unsigned K_BITS   = 64,
    parameter int unsigned LINK_REG = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic [3:0]        status,
    output logic [30:0]       controlWord,
    output logic [K_BITS-1:0] K,
    output logic [1:0]        state,
    output logic              illegal
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned FS_W  = 5;

    localparam logic [FS_W-1:0] FS_AND    = FS_W'(0);
    localparam logic [FS_W-1:0] FS_ORR    = FS_W'(1);
    localparam logic [FS_W-1:0] FS_ADD    = FS_W'(2);
    localparam logic [FS_W-1:0] FS_SUB    = FS_W'(3);
    localparam logic [FS_W-1:0] FS_PASS_B = FS_W'(4);

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EX0   = 2'd1,
        ST_EX1   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Field order matches the controlWord bit layout, MSB first.
    typedef struct packed {
        logic             mem_read;     // [30]
        logic             status_load;  // [29]
        logic             ir_load;      // [28]
        logic             pc_sel_reg;   // [27]
        logic             pc_load;      // [26]
        logic             pc_inc;       // [25]
        logic [1:0]       wb_sel;       // [24:23]
        logic             mem_write;    // [22]
        logic             rf_write;     // [21]
        logic             bsel_k;       // [20]
        logic [FS_W-1:0]  fs;           // [19:15]
        logic [REG_W-1:0] sb;           // [14:10]
        logic [REG_W-1:0] sa;           // [9:5]
        logic [REG_W-1:0] da;           // [4:0]
    } ctrl_t;

    state_t            state_q;
    state_t            state_d;
    ctrl_t             cw;
    logic [K_BITS-1:0] k_c;
    logic              illegal_c;

    logic [10:0]       opcode;
    logic              is_add, is_sub, is_and, is_orr, is_r_alu;
    logic              is_addi, is_ldur, is_stur, is_b, is_bl, is_br;
    logic              is_bcond, is_cbz, is_cbnz, is_cb, is_known;
    logic [FS_W-1:0]   fs_r;
    logic              cond_taken;
    logic              cb_taken;

    logic [K_BITS-1:0] k_addi;
    logic [K_BITS-1:0] k_dt;
    logic [K_BITS-1:0] k_br26;
    logic [K_BITS-1:0] k_br19;

    logic              flag_z, flag_n, flag_v;
    logic              unused_c;

    assign opcode   = instruction[31:21];
    assign flag_z   = status[0];
    assign flag_n   = status[1];
    assign flag_v   = status[3];
    // Carry is not consumed by any supported condition.
    assign unused_c = status[2];

    // Immediate extraction: zero-extended ALU immediate, signed offsets.
    assign k_addi = K_BITS'(instruction[21:10]);
    assign k_dt   = K_BITS'($signed(instruction[20:12]));
    assign k_br26 = K_BITS'($signed({instruction[25:0], 2'b00}));
    assign k_br19 = K_BITS'($signed({instruction[23:5], 2'b00}));

    // Opcode class decode.
    always_comb begin
        is_add   = (opcode == 11'b10001011000);
        is_sub   = (opcode == 11'b11001011000);
        is_and   = (opcode == 11'b10001010000);
        is_orr   = (opcode == 11'b10101010000);
        is_r_alu = is_add | is_sub | is_and | is_orr;
        is_addi  = (opcode[10:1] == 10'b1001000100);
        is_ldur  = (opcode == 11'b11111000010);
        is_stur  = (opcode == 11'b11111000000);
        is_b     = (opcode[10:5] == 6'b000101);
        is_bl    = (opcode[10:5] == 6'b100101);
        is_br    = (opcode == 11'b11010110000);
        is_bcond = (opcode[10:3] == 8'b01010100);
        is_cbz   = (opcode[10:3] == 8'b10110100);
        is_cbnz  = (opcode[10:3] == 8'b10110101);
        is_cb    = is_cbz | is_cbnz;
        is_known = is_r_alu | is_addi | is_ldur | is_stur | is_b | is_bl
                 | is_br | is_bcond | is_cb;

        fs_r = FS_AND;
        if (is_add)      fs_r = FS_ADD;
        else if (is_sub) fs_r = FS_SUB;
        else if (is_orr) fs_r = FS_ORR;
    end

    // Branch condition evaluation against the status flags.
    always_comb begin
        cond_taken = 1'b0;
        case (instruction[3:0])
            4'h0:    cond_taken = flag_z;
            4'h1:    cond_taken = ~flag_z;
            4'hA:    cond_taken = (flag_n == flag_v);
            4'hB:    cond_taken = (flag_n != flag_v);
            default: cond_taken = 1'b0;
        endcase
        cb_taken = is_cbz ? flag_z : ~flag_z;
    end

    // Sequencer state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and control word generation.
    always_comb begin
        cw        = '0;
        k_c       = '0;
        illegal_c = 1'b0;
        state_d   = state_q;

        case (state_q)
            ST_FETCH: begin
                cw.ir_load = 1'b1;
                state_d    = ST_EX0;
            end

            ST_EX0: begin
                state_d = ST_FETCH;
                if (is_known) begin
                    cw.da = instruction[4:0];
                    cw.sa = instruction[9:5];
                    cw.sb = instruction[20:16];
                end
                if (is_r_alu) begin
                    cw.rf_write = 1'b1;
                    cw.fs       = fs_r;
                    cw.pc_inc   = 1'b1;
                end else if (is_addi) begin
                    k_c         = k_addi;
                    cw.bsel_k   = 1'b1;
                    cw.fs       = FS_ADD;
                    cw.rf_write = 1'b1;
                    cw.pc_inc   = 1'b1;
                end else if (is_ldur) begin
                    k_c         = k_dt;
                    cw.bsel_k   = 1'b1;
                    cw.fs       = FS_ADD;
                    cw.mem_read = 1'b1;
                    state_d     = ST_EX1;
                end else if (is_stur) begin
                    k_c          = k_dt;
                    cw.bsel_k    = 1'b1;
                    cw.fs        = FS_ADD;
                    cw.sb        = instruction[4:0];
                    cw.mem_write = 1'b1;
                    cw.pc_inc    = 1'b1;
                end else if (is_b || is_bl) begin
                    k_c           = k_br26;
                    cw.pc_load    = 1'b1;
                    cw.pc_sel_reg = 1'b0;
                    if (is_bl) begin
                        cw.da       = REG_W'(LINK_REG);
                        cw.wb_sel   = WB_PC4;
                        cw.rf_write = 1'b1;
                    end
                end else if (is_br) begin
                    cw.pc_load    = 1'b1;
                    cw.pc_sel_reg = 1'b1;
                end else if (is_bcond) begin
                    k_c = k_br19;
                    if (cond_taken) cw.pc_load = 1'b1;
                    else            cw.pc_inc  = 1'b1;
                end else if (is_cb) begin
                    k_c            = k_br19;
                    cw.sb          = instruction[4:0];
                    cw.fs          = FS_PASS_B;
                    cw.status_load = 1'b1;
                    state_d        = ST_EX1;
                end else begin
                    illegal_c = 1'b1;
`ifdef MCU_ILLEGAL_TRAP_EN
                    state_d   = ST_HALT;
`else
                    cw.pc_inc = 1'b1;
`endif
                end
            end

            ST_EX1: begin
                state_d = ST_FETCH;
                if (is_ldur) begin
                    // Address path kept stable while memory data is written back.
                    cw.da       = instruction[4:0];
                    cw.sa       = instruction[9:5];
                    cw.sb       = instruction[20:16];
                    k_c         = k_dt;
                    cw.bsel_k   = 1'b1;
                    cw.fs       = FS_ADD;
                    cw.mem_read = 1'b1;
                    cw.wb_sel   = WB_MEM;
                    cw.rf_write = 1'b1;
                    cw.pc_inc   = 1'b1;
                end else if (is_cb) begin
                    // Z now reflects the register tested in EX0.
                    cw.da = instruction[4:0];
                    cw.sa = instruction[9:5];
                    cw.sb = instruction[4:0];
                    k_c   = k_br19;
                    if (cb_taken) cw.pc_load = 1'b1;
                    else          cw.pc_inc  = 1'b1;
                end
            end

            ST_HALT: begin
`ifdef MCU_ILLEGAL_TRAP_EN
                state_d = ST_HALT;
`else
                state_d = ST_FETCH;
`endif
            end

            default: state_d = ST_FETCH;
        endcase

        // Reset forces the FETCH pattern regardless of the held instruction.
        if (reset) begin
            cw         = '0;
            cw.ir_load = 1'b1;
            k_c        = '0;
            illegal_c  = 1'b0;
        end
    end

    assign controlWord = cw;
    assign K           = k_c;
    assign state       = state_q;
    assign illegal     = illegal_c;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: table vectors, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic [3:0]  status;
    logic [30:0] controlWord;
    logic [63:0] K;
    logic [1:0]  state;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    multicycle_control_unit #(.K_BITS(64), .LINK_REG(30)) dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .status      (status),
        .controlWord (controlWord),
        .K           (K),
        .state       (state),
        .illegal     (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [30:0] cw0;
        logic [63:0] k0;
        logic        ex1;
        logic [30:0] cw1;
        logic [63:0] k1;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Behavioural reference: field values from the instruction-class rules, packed arithmetically.
    function automatic void ref_model(input int phase, input logic [31:0] ins, input logic [3:0] st,
                                      output logic [30:0] cw, output logic [63:0] k,
                                      output logic ill, output int nxt);
        string  cls;
        int     da, sa, sb, fs, bk, rw, mw, wb, pi, pl, ps, sl, mr;
        longint kk, off9, off19, off26;
        logic   z, n, v, take;
        int     opc, top6, top8;
        opc  = int'(ins[31:21]);
        top6 = int'(ins[31:26]);
        top8 = int'(ins[31:24]);
        da = 0; sa = 0; sb = 0; fs = 0; bk = 0; rw = 0; mw = 0; wb = 0;
        pi = 0; pl = 0; ps = 0; sl = 0; mr = 0; kk = 0; ill = 1'b0; nxt = 0;
        off9  = ins[20] ? longint'(ins[20:12]) - 512 : longint'(ins[20:12]);
        off19 = (ins[23] ? longint'(ins[23:5]) - 524288 : longint'(ins[23:5])) * 4;
        off26 = (ins[25] ? longint'(ins[25:0]) - 67108864 : longint'(ins[25:0])) * 4;
        z = st[0]; n = st[1]; v = st[3];

        if      (opc == 'h458)        cls = "ADD";
        else if (opc == 'h658)        cls = "SUB";
        else if (opc == 'h450)        cls = "AND";
        else if (opc == 'h550)        cls = "ORR";
        else if ((opc >> 1) == 'h244) cls = "ADDI";
        else if (opc == 'h7C2)        cls = "LDUR";
        else if (opc == 'h7C0)        cls = "STUR";
        else if (top6 == 'h05)        cls = "B";
        else if (top6 == 'h25)        cls = "BL";
        else if (opc == 'h6B0)        cls = "BR";
        else if (top8 == 'h54)        cls = "BCOND";
        else if (top8 == 'hB4)        cls = "CBZ";
        else if (top8 == 'hB5)        cls = "CBNZ";
        else                          cls = "ILL";

        if (phase == 1) begin
            if (cls != "ILL") begin
                da = int'(ins[4:0]); sa = int'(ins[9:5]); sb = int'(ins[20:16]);
            end
            if (cls == "ADD" || cls == "SUB" || cls == "AND" || cls == "ORR") begin
                rw = 1; pi = 1;
                fs = (cls == "AND") ? 0 : (cls == "ORR") ? 1 : (cls == "ADD") ? 2 : 3;
            end else if (cls == "ADDI") begin
                kk = longint'(ins[21:10]); bk = 1; fs = 2; rw = 1; pi = 1;
            end else if (cls == "LDUR") begin
                kk = off9; bk = 1; fs = 2; mr = 1; nxt = 2;
            end else if (cls == "STUR") begin
                kk = off9; bk = 1; fs = 2; sb = int'(ins[4:0]); mw = 1; pi = 1;
            end else if (cls == "B" || cls == "BL") begin
                kk = off26; pl = 1;
                if (cls == "BL") begin da = 30; wb = 2; rw = 1; end
            end else if (cls == "BR") begin
                pl = 1; ps = 1;
            end else if (cls == "BCOND") begin
                kk = off19;
                case (int'(ins[3:0]))
                    0:       take = z;
                    1:       take = !z;
                    10:      take = (n == v);
                    11:      take = (n != v);
                    default: take = 1'b0;
                endcase
                if (take) pl = 1; else pi = 1;
            end else if (cls == "CBZ" || cls == "CBNZ") begin
                kk = off19; sb = int'(ins[4:0]); fs = 4; sl = 1; nxt = 2;
            end else begin
                ill = 1'b1;
`ifdef MCU_ILLEGAL_TRAP_EN
                nxt = 3;
`else
                pi = 1;
`endif
            end
        end else begin
            if (cls == "LDUR") begin
                da = int'(ins[4:0]); sa = int'(ins[9:5]); sb = int'(ins[20:16]);
                kk = off9; bk = 1; fs = 2; mr = 1; wb = 1; rw = 1; pi = 1;
            end else if (cls == "CBZ" || cls == "CBNZ") begin
                da = int'(ins[4:0]); sa = int'(ins[9:5]); sb = int'(ins[4:0]);
                kk = off19;
                take = (cls == "CBZ") ? z : !z;
                if (take) pl = 1; else pi = 1;
            end
        end
        cw = 31'(da + sa * 32 + sb * 1024 + fs * 32768 + bk * (1 << 20) + rw * (1 << 21)
                 + mw * (1 << 22) + wb * (1 << 23) + pi * (1 << 25) + pl * (1 << 26)
                 + ps * (1 << 27) + sl * (1 << 29) + mr * (1 << 30));
        k = 64'(kk);
    endfunction

    // Drive one instruction from FETCH to its completion, checking each cycle against the model.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] s0, input logic [3:0] s1,
                             input string tag);
        logic [30:0] ecw;
        logic [63:0] ek;
        logic        eill;
        int          enxt;
        int          dummy;
        instruction = ins;
        status      = s0;
        #1;
        check({tag, " fetch state"}, 64'(state), 64'd0);
        check({tag, " fetch cw"}, 64'(controlWord), 64'h1000_0000);
        tick();
        check({tag, " ex0 state"}, 64'(state), 64'd1);
        ref_model(1, ins, s0, ecw, ek, eill, enxt);
        check({tag, " ex0 cw"}, 64'(controlWord), 64'(ecw));
        check({tag, " ex0 K"}, K, ek);
        check({tag, " ex0 illegal"}, 64'(illegal), 64'(eill));
        tick();
        check({tag, " after ex0 state"}, 64'(state), 64'(enxt));
        if (enxt == 2) begin
            status = s1;
            #1;
            ref_model(2, ins, s1, ecw, ek, eill, dummy);
            check({tag, " ex1 cw"}, 64'(controlWord), 64'(ecw));
            check({tag, " ex1 K"}, K, ek);
            tick();
            check({tag, " after ex1 state"}, 64'(state), 64'd0);
        end else if (enxt == 3) begin
            for (int c = 0; c < 10; c++) begin
                check({tag, " halt state"}, 64'(state), 64'd3);
                check({tag, " halt cw"}, 64'(controlWord), 64'd0);
                tick();
            end
            reset = 1'b1;
            #1;
            check({tag, " halt reset state"}, 64'(state), 64'd0);
            reset = 1'b0;
        end
    endtask

    // Same flow as run_instr, but with hand-computed expectations from the table.
    task automatic apply_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        instruction = v.ins;
        status      = v.s0;
        #1;
        check({tag, " fetch cw"}, 64'(controlWord), 64'h1000_0000);
        tick();
        check({tag, " ex0 state"}, 64'(state), 64'd1);
        check({tag, " ex0 cw"}, 64'(controlWord), 64'(v.cw0));
        check({tag, " ex0 K"}, K, v.k0);
        check({tag, " ex0 illegal"}, 64'(illegal), 64'd0);
        tick();
        if (v.ex1) begin
            check({tag, " ex1 state"}, 64'(state), 64'd2);
            status = v.s1;
            #1;
            check({tag, " ex1 cw"}, 64'(controlWord), 64'(v.cw1));
            check({tag, " ex1 K"}, K, v.k1);
            tick();
        end
        check({tag, " end state"}, 64'(state), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        int          sel;

        vecs[0]  = '{32'h9100_1441, 4'h0, 4'h0, 31'h0231_0041, 64'd5, 1'b0, 31'h0, 64'h0};
        vecs[1]  = '{32'hF85F_8083, 4'h0, 4'h0, 31'h4011_7C83, 64'hFFFF_FFFF_FFFF_FFF8,
                     1'b1, 31'h42B1_7C83, 64'hFFFF_FFFF_FFFF_FFF8};
        vecs[2]  = '{32'h5400_0080, 4'h1, 4'h0, 31'h0400_0080, 64'd16, 1'b0, 31'h0, 64'h0};
        vecs[3]  = '{32'h5400_0080, 4'h0, 4'h0, 31'h0200_0080, 64'd16, 1'b0, 31'h0, 64'h0};
        vecs[4]  = '{32'hB500_0067, 4'h1, 4'h0, 31'h2002_1C67, 64'd12, 1'b1, 31'h0400_1C67, 64'd12};
        vecs[5]  = '{32'hB500_0067, 4'h0, 4'h1, 31'h2002_1C67, 64'd12, 1'b1, 31'h0200_1C67, 64'd12};
        vecs[6]  = '{32'hB400_0067, 4'h0, 4'h1, 31'h2002_1C67, 64'd12, 1'b1, 31'h0400_1C67, 64'd12};
        vecs[7]  = '{32'h8B07_00C5, 4'h0, 4'h0, 31'h0221_1CC5, 64'd0, 1'b0, 31'h0, 64'h0};
        vecs[8]  = '{32'hCB07_00C5, 4'h0, 4'h0, 31'h0221_9CC5, 64'd0, 1'b0, 31'h0, 64'h0};
        vecs[9]  = '{32'h8A07_00C5, 4'h0, 4'h0, 31'h0220_1CC5, 64'd0, 1'b0, 31'h0, 64'h0};
        vecs[10] = '{32'hAA07_00C5, 4'h0, 4'h0, 31'h0220_9CC5, 64'd0, 1'b0, 31'h0, 64'h0};
        vecs[11] = '{32'h9400_0001, 4'h0, 4'h0, 31'h0520_001E, 64'd4, 1'b0, 31'h0, 64'h0};
        vecs[12] = '{32'h17FF_FFFF, 4'h0, 4'h0, 31'h0400_7FFF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 31'h0, 64'h0};
        vecs[13] = '{32'hD600_0120, 4'h0, 4'h0, 31'h0C00_0120, 64'd0, 1'b0, 31'h0, 64'h0};
        vecs[14] = '{32'hF801_0041, 4'h0, 4'h0, 31'h0251_0441, 64'd16, 1'b0, 31'h0, 64'h0};
        vecs[15] = '{32'h5400_008B, 4'h2, 4'h0, 31'h0400_008B, 64'd16, 1'b0, 31'h0, 64'h0};
        vecs[16] = '{32'h5400_008E, 4'h0, 4'h0, 31'h0200_008E, 64'd16, 1'b0, 31'h0, 64'h0};
        vecs[17] = '{32'h5400_008A, 4'hA, 4'h0, 31'h0400_008A, 64'd16, 1'b0, 31'h0, 64'h0};

        // Reset asserted with an illegal opcode presented: only IR_load, no illegal flag.
        reset       = 1'b1;
        instruction = 32'h0;
        status      = 4'h0;
        #2;
        check("reset state", 64'(state), 64'd0);
        check("reset cw", 64'(controlWord), 64'h1000_0000);
        check("reset K", K, 64'd0);
        check("reset illegal", 64'(illegal), 64'd0);
        tick();
        reset = 1'b0;
        check("post-reset fetch state", 64'(state), 64'd0);
        check("post-reset fetch cw", 64'(controlWord), 64'h1000_0000);
        tick();
        check("first ex0 state", 64'(state), 64'd1);
        reset = 1'b1;
        #1;
        check("reset from ex0", 64'(state), 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Illegal opcode 0x000 in EX0.
        instruction = 32'h0;
        #1;
        tick();
        check("illegal flag", 64'(illegal), 64'd1);
`ifdef MCU_ILLEGAL_TRAP_EN
        check("illegal cw trap", 64'(controlWord), 64'd0);
        tick();
        for (int c = 0; c < 10; c++) begin
            check("halt hold state", 64'(state), 64'd3);
            check("halt hold cw", 64'(controlWord), 64'd0);
            check("halt hold K", K, 64'd0);
            tick();
        end
        reset = 1'b1;
        #1;
        check("halt reset state", 64'(state), 64'd0);
        reset = 1'b0;
`else
        check("illegal cw nop", 64'(controlWord), 64'h0200_0000);
        tick();
        check("illegal next state", 64'(state), 64'd0);
`endif

        // Foreign instruction in EX1 yields a zero control word.
        instruction = 32'hF85F_8083;
        #1;
        tick();
        tick();
        check("stray ex1 state", 64'(state), 64'd2);
        instruction = 32'h8B07_00C5;
        #1;
        check("stray ex1 cw", 64'(controlWord), 64'd0);
        check("stray ex1 K", K, 64'd0);
        tick();
        check("stray ex1 next", 64'(state), 64'd0);

        // Reset in EX1 drops the pending step; instruction then restarts cleanly.
        instruction = 32'hF85F_8083;
        #1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid reset state", 64'(state), 64'd0);
        check("mid reset cw", 64'(controlWord), 64'h1000_0000);
        check("mid reset K", K, 64'd0);
        reset = 1'b0;
        tick();
        check("mid reset ex0", 64'(state), 64'd1);
        tick();
        check("mid reset ex1", 64'(state), 64'd2);
        tick();
        check("mid reset done", 64'(state), 64'd0);

        // Randomized instruction stream against the reference model.
        for (int i = 0; i < 300; i++) begin
            r   = $urandom;
            sel = int'($urandom_range(0, 14));
            case (sel)
                0:       ins = {11'h458, r[20:0]};
                1:       ins = {11'h658, r[20:0]};
                2:       ins = {11'h450, r[20:0]};
                3:       ins = {11'h550, r[20:0]};
                4:       ins = {10'h244, r[21:0]};
                5:       ins = {11'h7C2, r[20:0]};
                6:       ins = {11'h7C0, r[20:0]};
                7:       ins = {6'h05, r[25:0]};
                8:       ins = {6'h25, r[25:0]};
                9:       ins = {11'h6B0, r[20:0]};
                10:      ins = {8'h54, r[23:0]};
                11:      ins = {8'hB4, r[23:0]};
                12:      ins = {8'hB5, r[23:0]};
                default: ins = r;
            endcase
            run_instr(ins, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-pass LEGv8 decode/control block. Holds a registered sequencer state (FETCH, EX0, EX1, HALT) and issues one packed control word plus a constant K per cycle. Supports multi-step instructions (LDUR, CBZ/CBNZ), condition evaluation against the status flags, and illegal-opcode detection. It sits between the externally held instruction register and the datapath (register file, ALU, memory, PC).

Parameters:
K_BITS, 64, width of the K constant output; immediates are extended to this width.
LINK_REG, 30, destination register index for BL.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instruction  input  32  current instruction; captured externally when IR_load=1 and held stable until the next FETCH
status  input  4  registered ALU flags: [3]V [2]C [1]N [0]Z
controlWord  output  31  packed control word, layout given under Behaviour
K  output  K_BITS  constant or offset for the datapath
state  output  2  FETCH=0, EX0=1, EX1=2, HALT=3
illegal  output  1  high in EX0 when the opcode is not recognised

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- controlWord fields: [4:0]DA, [9:5]SA, [14:10]SB, [19:15]FS, [20]Bsel_K, [21]RF_write, [22]MEM_write, [24:23]WB_sel (0 ALU, 1 MEM, 2 PC+4), [25]PC_inc, [26]PC_load, [27]PC_sel_reg (0 = PC+K, 1 = register A), [28]IR_load, [29]status_load, [30]MEM_read.
- FS codes: 0 AND, 1 ORR, 2 ADD, 3 SUB, 4 PASS_B.
- Timing: outputs are combinational from the registered state and the instruction; only the state register is clocked.
- Reset: state=FETCH. While reset is asserted, controlWord = IR_load only (all other bits 0), K=0, illegal=0. Reset in any state returns to FETCH with no pending step.
- FETCH: IR_load=1, all other bits 0. Next state is EX0.
- Decode is by opcode = instruction[31:21]. Default fields: Rd=[4:0] -> DA, Rn=[9:5] -> SA, Rm=[20:16] -> SB.
- R-ALU: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - EX0: RF_write, FS per op, PC_inc. Next state FETCH.
- ADDI: opcode[10:1]=1001000100.
  - EX0: K = zero-extended [21:10], Bsel_K, FS=ADD, RF_write, PC_inc. Next state FETCH.
- LDUR 11111000010:
  - EX0: K = sign-extended [20:12], Bsel_K, FS=ADD, MEM_read. Next state EX1.
  - EX1: same address fields, MEM_read, WB_sel=1, RF_write, PC_inc. Next state FETCH.
- STUR 11111000000:
  - EX0: K = sign-extended [20:12], Bsel_K, FS=ADD, SB=[4:0], MEM_write, PC_inc. Next state FETCH.
- B 000101xxxxx:
  - EX0: K = sign-extended [25:0] shifted left by 2, PC_load, PC_sel_reg=0. Next state FETCH.
- BL 100101xxxxx:
  - EX0: as B, plus DA=LINK_REG, WB_sel=2, RF_write. Next state FETCH.
- BR 11010110000:
  - EX0: SA=[9:5], PC_load, PC_sel_reg=1. Next state FETCH.
- B.cond, opcode[10:3]=01010100:
  - EX0: K = sign-extended [23:5] shifted left by 2.
  - cond=[3:0]: EQ(0) Z; NE(1) !Z; GE(0xA) N==V; LT(0xB) N!=V; any other code is never taken.
  - Taken: PC_load. Not taken: PC_inc. Next state FETCH.
- CBZ 10110100 / CBNZ 10110101:
  - EX0: SB=[4:0], FS=PASS_B, status_load, K = sign-extended [23:5] shifted left by 2. Next state EX1.
  - EX1: Z sampled from status (updated at the end of EX0). CBZ takes on Z=1; CBNZ takes on Z=0. Taken: PC_load. Not taken: PC_inc. Next state FETCH.
- K=0 for every class not listed above.
- Unrecognised opcode in EX0: illegal=1, PC_inc only. Next state FETCH (see Optional Feature).
- EX1 is reachable only from LDUR and CBZ/CBNZ. Any other instruction seen in EX1 yields controlWord=0 and next state FETCH.
- HALT (only with feature): controlWord=0, K=0; the state holds until reset.
- Each instruction therefore takes 2 cycles (FETCH+EX0) or 3 cycles (FETCH+EX0+EX1). PC_load and PC_inc are never both 1.

Optional Feature:
- Macro: MCU_ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode in EX0 drives illegal=1 with controlWord=0 (no PC_inc) and next state HALT. The block stays in HALT until reset.
- Undefined: an illegal opcode acts as a NOP (PC_inc, return to FETCH) and HALT is unreachable.

Test Plan:
1. Release reset, no instruction -> state goes 0 then 1; in FETCH, controlWord = only bit 28 set (0x10000000).
2. instruction=0x91001441 (ADDI X1,X2,#5) -> in EX0: K=5, DA=1, SA=2, FS=2, Bsel_K=1, RF_write=1, PC_inc=1; next state FETCH.
3. LDUR X3,[X4,#-8] -> EX0: K=0xFFFFFFFFFFFFFFF8, MEM_read=1, RF_write=0; EX1: WB_sel=1, RF_write=1, PC_inc=1; back to FETCH after 3 cycles total.
4. B.EQ imm19=4, checked with status Z=1 and again with Z=0 -> Z=1: K=16, PC_load=1; Z=0: PC_inc=1, PC_load=0.
5. CBNZ X7 with status Z=0 in EX1 -> EX0: SB=7, FS=4, status_load=1; EX1: PC_load=1. Repeat with Z=1 -> PC_inc=1.
6. opcode 0x000 in EX0 -> illegal=1. Without the macro: PC_inc=1 and next state FETCH. With MCU_ILLEGAL_TRAP_EN: state=3 holds for 10 cycles, then reset returns state to 0.
